cpu_rf: RTL

//  Next-generation tiny CPU: parametrised data/address width, register file of
//  num_regs general registers, Z/C flags, conditional branches and a memory-ready

---
 rtl/cpu_rf.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cpu_rf.sv
// Tiny von Neumann CPU: register file, Z/C flags, conditional branches and a
// wait-state handshake on one shared bus with combinational read data.
module cpu_rf #(
    parameter int                    addr_width = 8,
    parameter int                    data_width = 8,
    parameter int                    num_regs   = 4,
    parameter logic [addr_width-1:0] reset_pc   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  write,
    output logic [addr_width-1:0] addr,
    output logic [data_width-1:0] wdata,
    input  logic [data_width-1:0] rdata,
    input  logic                  mem_ready,
    output logic                  halted
);

    localparam int rw = $clog2(num_regs);

    if (data_width < 4 + 2 * rw) begin : g_width_check
        $error("cpu_rf: data_width too small to hold opcode and register fields");
    end

    localparam logic [3:0] OP_LDI = 4'd1, OP_LD = 4'd2, OP_ST = 4'd3, OP_MOV = 4'd4;
    localparam logic [3:0] OP_ADD = 4'd5, OP_SUB = 4'd6, OP_MUL = 4'd7, OP_DIV = 4'd8;
    localparam logic [3:0] OP_AND = 4'd9, OP_OR = 4'd10, OP_XOR = 4'd11;
    localparam logic [3:0] OP_JMP = 4'd12, OP_JZ = 4'd13, OP_JNZ = 4'd14, OP_HALT = 4'd15;

    typedef enum logic [2:0] {S_FETCH, S_OPERAND, S_LOAD, S_STORE, S_HALT} state_t;

    state_t                state, state_next;
    logic [addr_width-1:0] pc, ea, pc_inc;
    logic [3+rw:0]         ir;
    logic [data_width-1:0] regs [num_regs];
    logic                  flag_z, flag_c;

    logic [3:0]            f_op, x_op;
    logic [rw-1:0]         f_rd, f_rs, x_rd;
    logic                  f_two_word, f_alu;
    logic [data_width:0]   alu_out;

    // Returns {carry, result}; carry is borrow for SUB and high-half-nonzero for MUL.
    function automatic logic [data_width:0] alu(input logic [3:0] op,
                                                input logic [data_width-1:0] a,
                                                input logic [data_width-1:0] b);
        logic [2*data_width-1:0] prod;
        logic [data_width:0]     r;
        prod = {{data_width{1'b0}}, a} * {{data_width{1'b0}}, b};
        r = '0;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {(a < b), a - b};
            OP_MUL:  r = {(|prod[2*data_width-1:data_width]), prod[data_width-1:0]};
            OP_DIV:  r = (b == '0) ? {1'b1, {data_width{1'b1}}} : {1'b0, a / b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Single-word instructions are decoded straight off the bus during FETCH.
    assign f_op       = rdata[3:0];
    assign f_rd       = rdata[4+:rw];
    assign f_rs       = rdata[4+rw+:rw];
    assign x_op       = ir[3:0];
    assign x_rd       = ir[4+:rw];
    assign f_two_word = f_op inside {OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JZ, OP_JNZ};
    assign f_alu      = (f_op >= OP_ADD) && (f_op <= OP_XOR);
    assign alu_out    = alu(f_op, regs[f_rd], regs[f_rs]);
    assign pc_inc     = pc + addr_width'(1);

    always_comb begin
        state_next = state;
        addr       = pc;
        write      = 1'b0;
        wdata      = '0;
        halted     = 1'b0;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    if (f_op == OP_HALT)  state_next = S_HALT;
                    else if (f_two_word)  state_next = S_OPERAND;
                end
            end
            S_OPERAND: begin
                if (mem_ready) begin
                    if (x_op == OP_LD)      state_next = S_LOAD;
                    else if (x_op == OP_ST) state_next = S_STORE;
                    else                    state_next = S_FETCH;
                end
            end
            S_LOAD: begin
                addr = ea;
                if (mem_ready) state_next = S_FETCH;
            end
            S_STORE: begin
                addr  = ea;
                write = 1'b1;
                wdata = regs[x_rd];
                if (mem_ready) state_next = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            pc     <= reset_pc;
            ir     <= '0;
            ea     <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            for (int i = 0; i < num_regs; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            if (mem_ready) begin
                case (state)
                    S_FETCH: begin
                        pc <= pc_inc;
                        ir <= rdata[3+rw:0];
                        if (f_op == OP_MOV) regs[f_rd] <= regs[f_rs];
                        if (f_alu) begin
                            regs[f_rd] <= alu_out[data_width-1:0];
                            flag_c     <= alu_out[data_width];
                            flag_z     <= (alu_out[data_width-1:0] == '0);
                        end
                    end
                    S_OPERAND: begin
                        case (x_op)
                            OP_LDI: begin
                                regs[x_rd] <= rdata;
                                pc         <= pc_inc;
                            end
                            OP_JMP:  pc <= addr_width'(rdata);
                            OP_JZ:   pc <= flag_z ? addr_width'(rdata) : pc_inc;
                            OP_JNZ:  pc <= flag_z ? pc_inc : addr_width'(rdata);
                            default: begin
                                ea <= addr_width'(rdata);
                                pc <= pc_inc;
                            end
                        endcase
                    end
                    S_LOAD:  regs[x_rd] <= rdata;
                    default: ;
                endcase
            end
        end
    end

endmodule
